// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit timing
// used by both the transmitter wrapper and the receiver.
package uart_pkg;

  localparam int UART_D = 234;
  localparam int UART_L = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } RxState;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is a
// parameter so an idle-high line does not look like activity coming out of reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver with a valid/ready holding register, framing-error
// and overrun pulses. Defining UART_RX_PARITY_EN adds an even-parity bit and o_parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int D = UART_D,
  parameter int L = UART_L
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_rxd,
  output logic [L-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_frame_err,
  output logic         o_overrun,
  output logic         o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic         o_parity_err
`endif
);

  localparam int TW = $clog2(D);
  localparam int IW = $clog2(L);
  localparam logic [TW-1:0] HalfBit = TW'(D / 2 - 1);
  localparam logic [TW-1:0] FullBit = TW'(D - 1);
  localparam logic [IW-1:0] LastIdx = IW'(L - 1);

  logic rxs;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .async_i(i_rxd),
    .sync_o (rxs)
  );

  RxState        state_q;
  logic [TW-1:0] timer_q;
  logic [IW-1:0] bitIdx_q;
  logic [L-1:0]  shift_q;
  logic [L-1:0]  data_q;
  logic          valid_q;
  logic          frameErr_q;
  logic          overrun_q;
`ifdef UART_RX_PARITY_EN
  logic          parityBad_q;
  logic          parityErr_q;
`endif

  logic tick;
  assign tick = (timer_q == '0);

  // A consume and a new load can land in the same cycle; the load is written
  // last so it wins and o_valid stays high with the new byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErr_q <= 1'b0;
`endif
      if (valid_q && i_ready) valid_q <= 1'b0;
      if (!tick) timer_q <= timer_q - 1'b1;

      case (state_q)
        IDLE: begin
          if (!rxs) begin
            timer_q <= HalfBit;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rxs) begin
              state_q <= IDLE;
            end else begin
              timer_q  <= FullBit;
              bitIdx_q <= '0;
              state_q  <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift_q[bitIdx_q] <= rxs;
            timer_q           <= FullBit;
            bitIdx_q          <= bitIdx_q + 1'b1;
            if (bitIdx_q == LastIdx) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            parityBad_q <= (^shift_q) ^ rxs;
            timer_q     <= FullBit;
            state_q     <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (rxs) begin
              if (!valid_q || i_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              parityErr_q <= parityBad_q;
`endif
              state_q <= IDLE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frameErr_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parityErr_q;
`endif

endmodule
